// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RMISS = 2'd1,
      WRITE = 2'd2
   } dc_state_t;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port, synchronous valid clear.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES = 16,
   parameter int IDX_W = $clog2(LINES),
   parameter int TAG_W = WORD_W - IDX_W - 2
) (
   input  logic              clk,
   input  logic              clr_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [WORD_W-1:0] rd_data_o,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [WORD_W-1:0] wr_data_i
);

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [WORD_W-1:0] data;
   } line_t;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [WORD_W-1:0] data_q [LINES];
   line_t             rd_line;

   assign rd_line    = '{valid: valid_q[rd_idx_i], tag: tag_q[rd_idx_i], data: data_q[rd_idx_i]};
   assign rd_valid_o = rd_line.valid;
   assign rd_tag_o   = rd_line.tag;
   assign rd_data_o  = rd_line.data;

   // Only the valid bits are cleared; stale tag/data are harmless once invalid.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a multi-cycle memory handshake.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_dm
   import dcache_pkg::*;
#(
   parameter int LINES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [1:0]  dbg_state_o
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = WORD_W - IDX_W - 2;

   dc_state_t         state_q, state_d;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              line_valid;
   logic [TAG_W-1:0]  line_tag;
   logic [WORD_W-1:0] line_data;
   logic              hit;
   logic              arr_we;
   logic [WORD_W-1:0] arr_wdata;

   assign idx = DataAdr[IDX_W+1:2];
   assign tag = DataAdr[31:IDX_W+2];
   assign hit = line_valid && (line_tag == tag);

   // The core holds address/data stable while stalled, so the request is driven straight through.
   assign mem_addr    = DataAdr & ~32'h3;
   assign mem_wdata   = WriteDataM;
   assign dbg_state_o = state_q;

   dcache_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
      .clk        (clk),
      .clr_i      (!reset),
      .rd_idx_i   (idx),
      .rd_valid_o (line_valid),
      .rd_tag_o   (line_tag),
      .rd_data_o  (line_data),
      .we_i       (arr_we),
      .wr_idx_i   (idx),
      .wr_tag_i   (tag),
      .wr_data_i  (arr_wdata)
   );

   always_comb begin
      state_d   = state_q;
      StallM    = 1'b0;
      ReadDataM = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      arr_we    = 1'b0;
      arr_wdata = WriteDataM;
      if (reset) begin
         case (state_q)
            IDLE: begin
               if (MemWriteM) begin
                  StallM  = 1'b1;
                  state_d = WRITE;
               end else if (MemReadM) begin
                  if (hit) begin
                     ReadDataM = line_data;
                  end else begin
                     StallM  = 1'b1;
                     state_d = RMISS;
                  end
               end
            end
            RMISS: begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  ReadDataM = mem_rdata;
                  arr_we    = 1'b1;
                  arr_wdata = mem_rdata;
                  state_d   = IDLE;
               end else begin
                  StallM = 1'b1;
               end
            end
            WRITE: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               if (mem_ack) begin
                  // No write-allocate: only a line that already holds this address is refreshed.
                  arr_we  = hit;
                  state_d = IDLE;
               end else begin
                  StallM = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef DCACHE_STATS_EN
   logic        hit_evt, miss_evt;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   assign hit_evt  = reset && (state_q == IDLE) && !MemWriteM && MemReadM && hit;
   assign miss_evt = reset && (state_q == RMISS) && mem_ack;
   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Directed testbench for dcache_dm: driver tasks, a latency-programmable memory responder and a queue-based monitor.
module tb_dcache_dm;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [31:0] DataAdr, WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [1:0]  dbg_state;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   dcache_dm #(.LINES(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .DataAdr    (DataAdr),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .dbg_state_o(dbg_state)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_rd_q[$];
   logic [31:0] exp_stall_q[$];
   logic [64:0] exp_txn_q[$];
   logic [31:0] mem_model [logic [31:0]];
   int          lat = 0;
   bit          resp_en = 1'b1;
   bit          force_ack = 1'b0;
   int          exp_hits = 0;
   int          exp_misses = 0;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory responder: acks after the request has been held for lat cycles.
   initial begin
      int req_cnt = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h5A5A5A5A;
            force_ack = 1'b0;
            req_cnt   = 0;
         end else if (resp_en && reset && mem_req) begin
            req_cnt++;
            if (req_cnt == lat + 1) begin
               mem_ack = 1'b1;
               if (mem_we) mem_model[mem_addr] = mem_wdata;
               else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
               req_cnt = 0;
            end
         end else begin
            req_cnt = 0;
         end
      end
   end

   // Monitor: pops expectations when a request completes or a memory transaction is acked.
   initial begin
      int stall_run = 0;
      forever begin
         @(negedge clk);
         #3;
         if (!reset) begin
            stall_run = 0;
         end else begin
            if (mem_req && mem_ack) begin
               if (exp_txn_q.size() == 0) begin
                  chk("unexpected_mem_txn", {mem_we, mem_addr, mem_wdata}, 65'h0);
               end else begin
                  logic [64:0] e;
                  e = exp_txn_q.pop_front();
                  if (e[64]) chk("mem_write_txn", {mem_we, mem_addr, mem_wdata}, e);
                  else chk("mem_read_txn", {32'h0, mem_we, mem_addr}, {32'h0, e[64:32]});
               end
            end
            if (MemReadM || MemWriteM) begin
               if (StallM) begin
                  stall_run++;
               end else begin
                  if (exp_stall_q.size() == 0) chk("unexpected_completion", 65'(stall_run), 65'h1FFFF);
                  else chk("stall_cycles", 65'(stall_run), 65'(exp_stall_q.pop_front()));
                  stall_run = 0;
                  if (MemReadM && !MemWriteM) begin
                     if (exp_rd_q.size() == 0) chk("unexpected_read", 65'(ReadDataM), 65'h1FFFF);
                     else chk("read_data", 65'(ReadDataM), 65'(exp_rd_q.pop_front()));
                  end
               end
            end
         end
      end
   end

   // Issues one core request at a negedge and holds it until StallM drops.
   task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                         input int l, input bit exp_hit, input logic [31:0] exp_rd);
      int n = 0;
      lat = l;
      if (wr) begin
         exp_stall_q.push_back(32'(1 + l));
         exp_txn_q.push_back({1'b1, addr, wdata});
      end else if (exp_hit) begin
         exp_stall_q.push_back(32'd0);
         exp_rd_q.push_back(exp_rd);
         exp_hits++;
      end else begin
         exp_stall_q.push_back(32'(1 + l));
         exp_txn_q.push_back({1'b0, addr, 32'h0});
         exp_rd_q.push_back(exp_rd);
         exp_misses++;
      end
      MemWriteM  = wr;
      MemReadM   = rd;
      DataAdr    = addr;
      WriteDataM = wdata;
      forever begin
         #1;
         if (!StallM) break;
         n++;
         if (n > 60) begin
            chk("request_timeout", 65'(n), 65'd0);
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      MemReadM = 1'b0; MemWriteM = 1'b0; DataAdr = '0; WriteDataM = '0;
      mem_model[32'h100] = 32'hDEADBEEF;
      mem_model[32'h140] = 32'hCAFEF00D;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_stall", 65'(StallM), 65'd0);
      chk("reset_mem_req", 65'(mem_req), 65'd0);
      chk("reset_read_data", 65'(ReadDataM), 65'd0);
      chk("reset_state", 65'(dbg_state), 65'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      do_req(0, 1, 32'h100, 0, 3, 0, 32'hDEADBEEF);
      do_req(0, 1, 32'h100, 0, 0, 1, 32'hDEADBEEF);
      do_req(1, 0, 32'h100, 32'h12345678, 2, 0, 0);
      do_req(0, 1, 32'h100, 0, 0, 1, 32'h12345678);
      do_req(0, 1, 32'h140, 0, 1, 0, 32'hCAFEF00D);
      do_req(0, 1, 32'h100, 0, 0, 0, 32'h12345678);
      do_req(0, 1, 32'h140, 0, 2, 0, 32'hCAFEF00D);
      do_req(1, 0, 32'h200, 32'hAAAA5555, 1, 0, 0);
      do_req(0, 1, 32'h140, 0, 0, 1, 32'hCAFEF00D);
      do_req(0, 1, 32'h200, 0, 1, 0, 32'hAAAA5555);
      do_req(0, 1, 32'h200, 0, 0, 1, 32'hAAAA5555);
      do_req(1, 1, 32'h104, 32'h00000077, 1, 0, 0);
      do_req(0, 1, 32'h104, 0, 2, 0, 32'h00000077);
      do_req(0, 1, 32'h100, 0, 1, 0, 32'h12345678);
      do_req(0, 1, 32'h100, 0, 0, 1, 32'h12345678);
`ifdef DCACHE_STATS_EN
      chk("hit_cnt", 65'(hit_cnt), 65'(exp_hits));
      chk("miss_cnt", 65'(miss_cnt), 65'(exp_misses));
`endif

      // Abandon a read miss with reset, then deliver a stray ack.
      resp_en  = 1'b0;
      MemReadM = 1'b1;
      DataAdr  = 32'h108;
      repeat (3) @(negedge clk);
      #1;
      chk("pre_reset_stall", 65'(StallM), 65'd1);
      chk("pre_reset_state", 65'(dbg_state), 65'd1);
      @(negedge clk);
      MemReadM = 1'b0;
      reset    = 1'b0;
      exp_hits = 0;
      exp_misses = 0;
      @(negedge clk);
      reset     = 1'b1;
      force_ack = 1'b1;
      @(negedge clk);
      #1;
      chk("stray_ack_seen", 65'(mem_ack), 65'd1);
      chk("stray_ack_state", 65'(dbg_state), 65'd0);
      chk("stray_ack_stall", 65'(StallM), 65'd0);
      chk("stray_ack_req", 65'(mem_req), 65'd0);
`ifdef DCACHE_STATS_EN
      chk("hit_cnt_reset", 65'(hit_cnt), 65'd0);
      chk("miss_cnt_reset", 65'(miss_cnt), 65'd0);
`endif
      @(negedge clk);
      #1;
      chk("post_ack_state", 65'(dbg_state), 65'd0);
      chk("post_ack_req", 65'(mem_req), 65'd0);
      resp_en = 1'b1;
      @(negedge clk);
      do_req(0, 1, 32'h100, 0, 1, 0, 32'h12345678);
`ifdef DCACHE_STATS_EN
      chk("hit_cnt_final", 65'(hit_cnt), 65'(exp_hits));
      chk("miss_cnt_final", 65'(miss_cnt), 65'(exp_misses));
`endif

      repeat (3) @(negedge clk);
      chk("rd_queue_drained", 65'(exp_rd_q.size()), 65'd0);
      chk("stall_queue_drained", 65'(exp_stall_q.size()), 65'd0);
      chk("txn_queue_drained", 65'(exp_txn_q.size()), 65'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipelined core's Memory stage (DataAdr, WriteDataM, MemWriteM, ReadDataM) and a multi-cycle backing data memory.
- Read hits complete with zero stall. Read misses and all writes stall the core via StallM until the backing memory acknowledges.

Parameters:
- LINES, 16, number of one-word cache lines; power of 2, at least 2.
- IDX_W, $clog2(LINES), index width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous active-low reset (0 = reset).
- MemReadM  input  1  core load request.
- MemWriteM  input  1  core store request.
- DataAdr  input  32  byte address; bits [1:0] ignored.
- WriteDataM  input  32  store data.
- ReadDataM  output  32  load data.
- StallM  output  1  core must hold its request stable and not advance.
- mem_req  output  1  backing-memory request.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  32  word-aligned address ({DataAdr[31:2],2'b00}).
- mem_wdata  output  32  write data.
- mem_rdata  input  32  read data, valid when mem_ack=1.
- mem_ack  input  1  one-cycle completion pulse.

Behaviour:
- Address split:
  - index = DataAdr[IDX_W+1:2]
  - tag = DataAdr[31:IDX_W+2]
- Per-line storage: valid bit, tag, 32-bit data.
- Hit condition: valid[index] && tag match.
- FSM states: IDLE, RMISS, WRITE.
- Reset (reset==0 at posedge):
  - state goes to IDLE.
  - All valid bits are cleared; data and tag arrays are not reset.
  - mem_req=0, StallM=0, ReadDataM=0 (ReadDataM is 0 whenever no read is outstanding).
  - Reset mid-RMISS/WRITE abandons the transaction. An mem_ack arriving after reset is ignored.
- IDLE behaviour:
  - MemWriteM=1: MemWriteM has priority over MemReadM when both are asserted. Go to WRITE; StallM=1 combinationally this cycle.
  - MemReadM=1 and hit: ReadDataM = line data combinationally; StallM=0; stay in IDLE.
  - MemReadM=1 and miss: go to RMISS; StallM=1 combinationally.
  - Neither asserted: StallM=0, mem_req=0.
- RMISS:
  - mem_req=1, mem_we=0, mem_addr driven from DataAdr, StallM=1.
  - On the mem_ack cycle:
    - ReadDataM = mem_rdata and StallM=0 (the core advances on this edge).
    - The line is written at the edge: valid=1, tag, data.
    - Next state is IDLE.
- WRITE:
  - mem_req=1, mem_we=1, mem_wdata=WriteDataM, StallM=1.
  - On the mem_ack cycle:
    - StallM=0; next state is IDLE.
    - If the line hits, its data is updated at the same edge.
    - On a miss, no allocation; the line is unchanged.
- mem_req, mem_addr, mem_we and mem_wdata stay stable until ack. mem_req drops the cycle after ack. There are no back-to-back requests without one IDLE cycle.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss or any write: 1 (IDLE decision) + k stall cycles, where k = cycles until ack.
- mem_ack while in IDLE is ignored.
- The core holding DataAdr/WriteDataM stable while StallM=1 is a core requirement; the cache does not latch them.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments once per read hit accepted in IDLE.
  - miss_cnt increments once per RMISS ack.
  - Writes are not counted.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - typedef enum logic [1:0] {IDLE, RMISS, WRITE} dc_state_t.
  - WORD_W=32.
  - Line struct typedef (valid, tag, data), parameterised by IDX_W via a localparam in the module.
- Sub-module dcache_array:
  - The valid/tag/data storage.
  - Read port is combinational; write port is synchronous; provides a synchronous valid clear.
  - The top holds the FSM and handshake.

Test Plan:
- Reset then read 0x100 with ack after 3 cycles, mem_rdata=0xDEADBEEF -> StallM high for 4 cycles, ReadDataM=0xDEADBEEF on ack cycle, one mem_req read transaction to 0x100.
- Re-read 0x100 -> StallM=0, ReadDataM=0xDEADBEEF same cycle, mem_req stays 0.
- Write 0x12345678 to 0x100 (hit) then read 0x100 -> write-through transaction seen (mem_we=1, mem_wdata=0x12345678); subsequent read hits returning 0x12345678.
- With LINES=16, read 0x100 then 0x140 (same index, different tag) then 0x100 -> three misses; final read returns the memory value for 0x100.
- Write 0x200 (miss) then read 0x200 -> the write does not allocate; the read misses.
- Reset asserted during RMISS wait, ack pulses 1 cycle after reset release -> state IDLE, StallM=0, ack ignored, previous hit at 0x100 now misses. With DCACHE_STATS_EN defined, confirm hit_cnt/miss_cnt match the counts above.
